// File: rtl/multi_delay_stim_pkg.sv
// Shared types for the a |-> ##DELAY b stimulus generator and its scoreboard.
package multi_delay_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_PULSE,
    ST_WAIT,
    ST_B_SLOT,
    ST_GAP,
    ST_FINISH
  } stim_state_e;

  typedef enum logic [1:0] {
    EXP_NONE,
    EXP_PASS,
    EXP_FAIL
  } exp_e;

endpackage

// File: rtl/multi_delay_scoreboard.sv
// Delays each predicted checker outcome by CHK_LAT cycles and matches it against
// the checker's pass/fail strobes, keeping saturating statistics.
module multi_delay_scoreboard
  import multi_delay_stim_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int CHK_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  exp_e             push_exp,
  input  logic             assertion_pass,
  input  logic             assertion_fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             mismatch
);

  exp_e exp_now;

  generate
    if (CHK_LAT == 0) begin : g_lat0
      assign exp_now = push ? push_exp : EXP_NONE;
    end else begin : g_line
      exp_e line_q [CHK_LAT];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < CHK_LAT; i++) line_q[i] <= EXP_NONE;
        end else begin
          line_q[0] <= push ? push_exp : EXP_NONE;
          for (int i = 1; i < CHK_LAT; i++) line_q[i] <= line_q[i-1];
        end
      end

      assign exp_now = line_q[CHK_LAT-1];
    end
  endgenerate

  logic hit_pass;
  logic hit_fail;
  logic miss;

  // Both strobes together never count as a match, whatever was expected.
  always_comb begin
    hit_pass = (exp_now == EXP_PASS) && assertion_pass && !assertion_fail;
    hit_fail = (exp_now == EXP_FAIL) && assertion_fail && !assertion_pass;
    miss     = !hit_pass && !hit_fail &&
               ((exp_now != EXP_NONE) || assertion_pass || assertion_fail);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      mismatch_cnt <= '0;
      mismatch     <= 1'b0;
    end else if (clear) begin
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      mismatch_cnt <= '0;
      mismatch     <= 1'b0;
    end else begin
      mismatch <= miss;
      if (hit_pass && (pass_cnt != '1))     pass_cnt     <= pass_cnt + CNT_W'(1);
      if (hit_fail && (fail_cnt != '1))     fail_cnt     <= fail_cnt + CNT_W'(1);
      if (miss && (mismatch_cnt != '1))     mismatch_cnt <= mismatch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multi_delay_stim_gen.sv
// Drives a/b transaction pulses for an a |-> ##DELAY b checker, predicting and
// scoring the checker's pass/fail outcome for each transaction.
//
// state      | meaning
// IDLE       | waiting for start
// A_PULSE    | a high; also the b slot when delay is 0
// WAIT       | delay-1 quiet cycles between a and b
// B_SLOT     | b high unless failure is injected; expectation pushed
// GAP        | GAP_CYC quiet cycles, then next transaction or finish
// FINISH     | one-cycle done pulse
module multi_delay_stim_gen
  import multi_delay_stim_pkg::*;
#(
  parameter int DW        = 4,
  parameter int MAX_DELAY = 8,
  parameter int CNT_W     = 16,
  parameter int CHK_LAT   = 1,
  parameter int GAP_CYC   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DW-1:0]    delay,
  input  logic [CNT_W-1:0] num_txn,
  input  logic             inject_fail,
  input  logic             assertion_pass,
  input  logic             assertion_fail,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             mismatch
);

  generate
    if (GAP_CYC < CHK_LAT) begin : g_bad_gap
      $error("GAP_CYC must be >= CHK_LAT so every outcome is scored before done");
    end
    if (CHK_LAT < 0 || CHK_LAT > 7) begin : g_bad_lat
      $error("CHK_LAT must be in 0..7");
    end
  endgenerate

  localparam int TMR_MAX = (MAX_DELAY > GAP_CYC) ? MAX_DELAY : GAP_CYC;
  localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [DW-1:0] MAX_D = DW'(MAX_DELAY);

  stim_state_e      state_q, state_d;
  logic [DW-1:0]    dly_q, dly_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             inj_q, inj_d;
  logic [TW-1:0]    tmr_q, tmr_d;

  logic clear;
  logic push;
  exp_e push_exp;
  logic slot_done;
  logic txn_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      rem_q   <= '0;
      inj_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      rem_q   <= rem_d;
      inj_q   <= inj_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    rem_d     = rem_q;
    inj_d     = inj_q;
    tmr_d     = tmr_q;
    a         = 1'b0;
    b         = 1'b0;
    done      = 1'b0;
    clear     = 1'b0;
    push      = 1'b0;
    push_exp  = EXP_NONE;
    slot_done = 1'b0;
    txn_done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dly_d   = (delay > MAX_D) ? MAX_D : delay;
          rem_d   = num_txn;
          inj_d   = inject_fail;
          clear   = 1'b1;
          state_d = (num_txn == '0) ? ST_FINISH : ST_A_PULSE;
        end
      end
      ST_A_PULSE: begin
        a = 1'b1;
        if (dly_q == '0) begin
          b         = !inj_q;
          push      = 1'b1;
          push_exp  = inj_q ? EXP_FAIL : EXP_PASS;
          slot_done = 1'b1;
        end else if (dly_q == DW'(1)) begin
          state_d = ST_B_SLOT;
        end else begin
          tmr_d   = TW'(dly_q - DW'(2));
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tmr_q == '0) state_d = ST_B_SLOT;
        else             tmr_d   = tmr_q - TW'(1);
      end
      ST_B_SLOT: begin
        b         = !inj_q;
        push      = 1'b1;
        push_exp  = inj_q ? EXP_FAIL : EXP_PASS;
        slot_done = 1'b1;
      end
      ST_GAP: begin
        if (tmr_q == '0) txn_done = 1'b1;
        else             tmr_d    = tmr_q - TW'(1);
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // With no gap configured the b slot closes the transaction directly.
    if (slot_done) begin
      if (GAP_CYC > 0) begin
        state_d = ST_GAP;
        tmr_d   = TW'(GAP_CYC - 1);
      end else begin
        txn_done = 1'b1;
      end
    end

    if (txn_done) begin
      rem_d   = rem_q - CNT_W'(1);
      state_d = (rem_q > CNT_W'(1)) ? ST_A_PULSE : ST_FINISH;
    end
  end

  assign busy = (state_q != ST_IDLE);

  multi_delay_scoreboard #(
    .CNT_W   (CNT_W),
    .CHK_LAT (CHK_LAT)
  ) u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .push           (push),
    .push_exp       (push_exp),
    .assertion_pass (assertion_pass),
    .assertion_fail (assertion_fail),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .mismatch_cnt   (mismatch_cnt),
    .mismatch       (mismatch)
  );

endmodule

// File: tb/tb_multi_delay_stim_gen.sv
// Scoreboard bench: an ideal a |-> ##d b checker model answers the DUT, and
// expected pulse timing and end-of-run statistics are queued per run.
module tb_multi_delay_stim_gen;

  localparam int DW   = 4;
  localparam int MAXD = 8;
  localparam int CW   = 16;
  localparam int LAT  = 1;
  localparam int GAP  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start, inject_fail, assertion_pass, assertion_fail;
  logic [DW-1:0] delay;
  logic [CW-1:0] num_txn;
  logic          a, b, busy, done, mismatch;
  logic [CW-1:0] pass_cnt, fail_cnt, mismatch_cnt;

  multi_delay_stim_gen #(
    .DW(DW), .MAX_DELAY(MAXD), .CNT_W(CW), .CHK_LAT(LAT), .GAP_CYC(GAP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .delay(delay), .num_txn(num_txn),
    .inject_fail(inject_fail), .assertion_pass(assertion_pass),
    .assertion_fail(assertion_fail), .a(a), .b(b), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .mismatch_cnt(mismatch_cnt),
    .mismatch(mismatch)
  );

  // Narrow-counter instance for saturation.
  logic          start2, inj2, ap2, af2;
  logic [DW-1:0] delay2;
  logic [1:0]    num2;
  logic          a2, b2, busy2, done2, mm2;
  logic [1:0]    pc2, fc2, mc2;

  multi_delay_stim_gen #(
    .DW(DW), .MAX_DELAY(MAXD), .CNT_W(2), .CHK_LAT(LAT), .GAP_CYC(GAP)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .delay(delay2), .num_txn(num2),
    .inject_fail(inj2), .assertion_pass(ap2), .assertion_fail(af2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .pass_cnt(pc2),
    .fail_cnt(fc2), .mismatch_cnt(mc2), .mismatch(mm2)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ideal checker model: an a seen at cycle c is judged on b at c+d and
  // reported LAT cycles later; flip_left turns pending passes into fails.
  int chk_d = 0;
  int flip_left = 0;
  bit pend_chk[int];
  bit pass_at[int];
  bit fail_at[int];

  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (a) pend_chk[cyc + chk_d] = 1'b1;
      if (pend_chk.exists(cyc)) begin
        pend_chk.delete(cyc);
        if (b && flip_left == 0) pass_at[cyc + LAT] = 1'b1;
        else begin
          if (b) flip_left--;
          fail_at[cyc + LAT] = 1'b1;
        end
      end
    end
  end

  initial begin
    assertion_pass = 1'b0;
    assertion_fail = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      assertion_pass = pass_at.exists(cyc);
      assertion_fail = fail_at.exists(cyc);
    end
  end

  // Ideal checker for dut2 (always run with delay 0).
  int mm2_pulses = 0;
  initial begin
    logic pend2;
    ap2 = 1'b0;
    forever begin
      @(negedge clk);
      pend2 = a2 & b2 & rst;
      if (mm2) mm2_pulses++;
      @(posedge clk);
      #1;
      ap2 = pend2;
    end
  end

  typedef struct {
    int cyc;
    int pc;
    int fc;
    int mc;
  } done_t;

  int    exp_a[$];
  int    exp_b[$];
  done_t exp_done[$];
  int    mm_pulses = 0;

  initial forever begin
    @(negedge clk);
    if (mismatch) mm_pulses++;
    if (a) begin
      check("a_expected", exp_a.size() != 0, 1);
      if (exp_a.size() != 0) check("a_cycle", cyc, exp_a.pop_front());
      check("busy_at_a", busy, 1);
    end
    if (b) begin
      check("b_expected", exp_b.size() != 0, 1);
      if (exp_b.size() != 0) check("b_cycle", cyc, exp_b.pop_front());
    end
    if (done) begin
      check("done_expected", exp_done.size() != 0, 1);
      if (exp_done.size() != 0) begin
        done_t e;
        e = exp_done.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("pass_cnt", pass_cnt, e.pc);
        check("fail_cnt", fail_cnt, e.fc);
        check("mismatch_cnt", mismatch_cnt, e.mc);
        check("mismatch_pulses", mm_pulses, e.mc);
        check("busy_at_done", busy, 1);
      end
    end
  end

  task automatic launch(input int d, input int n, input bit inj, input int flips);
    int    dd;
    int    p;
    int    t;
    done_t e;
    dd = (d > MAXD) ? MAXD : d;
    p  = dd + 1 + GAP;
    t  = cyc;
    for (int k = 0; k < n; k++) begin
      exp_a.push_back(t + 1 + k * p);
      if (!inj) exp_b.push_back(t + 1 + dd + k * p);
    end
    e.cyc = t + 1 + n * p;
    e.pc  = inj ? 0 : n - flips;
    e.fc  = inj ? n : 0;
    e.mc  = inj ? 0 : flips;
    exp_done.push_back(e);
    chk_d       = dd;
    flip_left   = flips;
    mm_pulses   = 0;
    delay       = DW'(d);
    num_txn     = CW'(n);
    inject_fail = inj;
    start       = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic finish_wait();
    int k = 0;
    while (exp_done.size() != 0 && k < 400) begin
      step(1);
      k++;
    end
    check("run_finished", exp_done.size(), 0);
    check("a_leftover", exp_a.size(), 0);
    check("b_leftover", exp_b.size(), 0);
    check("busy_after_done", busy, 0);
    exp_a.delete();
    exp_b.delete();
    exp_done.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    start = 1'b0; delay = '0; num_txn = '0; inject_fail = 1'b0;
    start2 = 1'b0; delay2 = '0; num2 = '0; inj2 = 1'b0; af2 = 1'b0;
    step(3);
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_pass_cnt", pass_cnt, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    check("rst_mismatch_cnt", mismatch_cnt, 0);
    rst = 1'b1;
    step(2);

    launch(3, 4, 1'b0, 0); finish_wait();   // basic passes
    launch(2, 3, 1'b1, 0); finish_wait();   // injected fails
    launch(0, 2, 1'b0, 0); finish_wait();   // a and b together
    launch(15, 2, 1'b0, 0); finish_wait();  // clamped to MAX_DELAY

    // Forced fail where a pass is due, then a spurious pass in IDLE.
    launch(3, 1, 1'b0, 1); finish_wait();
    pass_at[cyc + 1] = 1'b1;
    step(4);
    check("spurious_mismatch_cnt", mismatch_cnt, 2);
    check("spurious_pass_cnt", pass_cnt, 0);
    check("spurious_mismatch_pulses", mm_pulses, 2);

    launch(5, 0, 1'b0, 0); finish_wait();   // zero transactions

    // start while busy and in the FINISH cycle must both be ignored.
    launch(2, 3, 1'b0, 0);
    step(4);
    delay = 4'd0; num_txn = CW'(7); start = 1'b1;
    step(1);
    start = 1'b0;
    k = 0;
    while (exp_done.size() != 0 && cyc < exp_done[0].cyc && k < 400) begin
      step(1);
      k++;
    end
    delay = 4'd1; num_txn = CW'(2); start = 1'b1;
    step(1);
    start = 1'b0;
    finish_wait();
    step(3);
    check("no_restart_busy", busy, 0);

    // Reset during WAIT of transaction 2 of 5.
    launch(4, 5, 1'b0, 0);
    k = 0;
    while (exp_a.size() > 3 && k < 100) begin
      step(1);
      k++;
    end
    check("second_a_seen", exp_a.size(), 3);
    step(2);
    #2 rst = 1'b0;
    #1;
    check("midrst_a", a, 0);
    check("midrst_b", b, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_mismatch", mismatch, 0);
    check("midrst_pass_cnt", pass_cnt, 0);
    check("midrst_mismatch_cnt", mismatch_cnt, 0);
    exp_a.delete(); exp_b.delete(); exp_done.delete();
    pend_chk.delete(); pass_at.delete(); fail_at.delete();
    step(2);
    rst = 1'b1;
    step(2);
    launch(1, 2, 1'b0, 0); finish_wait();

    // Randomized runs.
    for (int i = 0; i < 8; i++) begin
      int  d, n, fl;
      bit  inj;
      d   = $urandom_range(0, 15);
      n   = $urandom_range(0, 4);
      inj = 1'($urandom_range(0, 1));
      fl  = inj ? 0 : $urandom_range(0, n);
      launch(d, n, inj, fl);
      finish_wait();
      step($urandom_range(0, 3));
    end

    // Narrow counters: three matched passes, then five spurious fails.
    num2 = 2'd3; delay2 = 4'd0; start2 = 1'b1;
    k = cyc;
    step(1);
    start2 = 1'b0;
    while (!done2 && cyc < k + 100) step(1);
    check("n2_done_cycle", cyc, k + 1 + 3 * (1 + GAP));
    check("n2_pass_cnt", pc2, 3);
    check("n2_mismatch_cnt", mc2, 0);
    mm2_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      af2 = 1'b1;
      step(1);
      af2 = 1'b0;
      step(1);
    end
    step(2);
    check("n2_mismatch_sat", mc2, 3);
    check("n2_mismatch_pulses", mm2_pulses, 5);
    check("n2_pass_hold", pc2, 3);
    check("n2_fail_cnt", fc2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
